// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern and length.
// Supports overlapping and non-overlapping matching, plus a saturating hit counter.
module seq_detect_param #(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1011),
    parameter int                 DEF_LEN = 4,
    parameter bit                 DEF_OVL = 1'b1,
    localparam int                LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat_val,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_y;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sample;
    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_hit;

    assign w_sample    = in_valid && !cfg_load;
    assign w_hist_n    = {r_hist[MAX_LEN-2:0], in};
    assign w_fill_n    = (r_fill == MAXL) ? r_fill : r_fill + 1'b1;
    assign w_len_clamp = (pat_len > MAXL) ? MAXL : pat_len;

    // Mask selects the low len_r history bits that take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_hit = w_sample && (r_len != '0) && (w_fill_n >= r_len) &&
                   ((w_hist_n & w_mask) == (r_pat & w_mask));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= DEF_PAT;
            r_len  <= LEN_W'(DEF_LEN);
            r_ovl  <= DEF_OVL;
            r_y    <= 1'b0;
        end else if (cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= pat_val;
            r_len  <= w_len_clamp;
            r_ovl  <= overlap;
            r_y    <= 1'b0;
        end else if (in_valid) begin
            r_hist <= w_hist_n;
            r_y    <= w_hit;
            // Non-overlap restarts the fill so matched bits cannot be reused.
            r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_n;
        end else begin
            r_y    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_hit && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign y         = r_y;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scenario bench for seq_detect_param: default and CNT_W=2 instances
// share one stimulus stream; expected pulses go through a queue.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in;
    logic       cfg_load;
    logic [7:0] pat_val;
    logic [3:0] pat_len;
    logic       overlap;
    logic       cnt_clr;
    logic       y;
    logic [7:0] match_cnt;
    logic       y2;
    logic [1:0] cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    logic q_y[$];
    int   q_c[$];

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
        .cfg_load(cfg_load), .pat_val(pat_val), .pat_len(pat_len),
        .overlap(overlap), .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
        .cfg_load(cfg_load), .pat_val(pat_val), .pat_len(pat_len),
        .overlap(overlap), .cnt_clr(cnt_clr), .y(y2), .match_cnt(cnt2)
    );

    task automatic step(input logic b, input logic v);
        in       = b;
        in_valid = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // The bit offered during the load edge must be discarded.
    task automatic load(input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic clr);
        cfg_load = 1'b1;
        pat_val  = p;
        pat_len  = l;
        overlap  = o;
        cnt_clr  = clr;
        in       = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] bits = 7'b1011011;
        logic [6:0] ex   = 7'b0001001;
        logic e;
        reset = 1'b0;
        #4;
        n_tests++;
        if (y !== 1'b0 || match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: y=%b cnt=%0d, expected 0 0", y, match_cnt);
        end
        #6;
        reset = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            q_y.push_back(ex[i]);
            step(bits[i], 1'b1);
            e = q_y.pop_front();
            n_tests++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL default_bit%0d: y=%b expected %b", 7 - i, y, e);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL default_cnt: cnt=%0d expected 2", match_cnt);
        end
    endtask

    task automatic test_non_overlap;
        logic [6:0] bits = 7'b1011011;
        logic [6:0] ex   = 7'b0001000;
        logic e;
        load(8'h0B, 4'd4, 1'b0, 1'b1);
        n_tests++;
        if (y !== 1'b0 || match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL nonovl_load: y=%b cnt=%0d expected 0 0", y, match_cnt);
        end
        for (int i = 6; i >= 0; i--) begin
            q_y.push_back(ex[i]);
            step(bits[i], 1'b1);
            e = q_y.pop_front();
            n_tests++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL nonovl_bit%0d: y=%b expected %b", 7 - i, y, e);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL nonovl_cnt: cnt=%0d expected 1", match_cnt);
        end
    endtask

    task automatic test_len_zero;
        logic [3:0] bits = 4'b1011;
        logic e;
        load(8'h0B, 4'd0, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            q_y.push_back(1'b0);
            step(bits[i], 1'b1);
            e = q_y.pop_front();
            n_tests++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL len0_bit%0d: y=%b expected %b", 4 - i, y, e);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL len0_cnt: cnt=%0d expected 0", match_cnt);
        end
    endtask

    task automatic test_clamp;
        logic e;
        load(8'hFF, 4'd9, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            q_y.push_back(i >= 8);
            step(1'b1, 1'b1);
            e = q_y.pop_front();
            n_tests++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL clamp_bit%0d: y=%b expected %b", i, y, e);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL clamp_cnt: cnt=%0d expected 3", match_cnt);
        end
    endtask

    task automatic test_gap;
        logic [6:0] bits = 7'b1000011;
        logic [6:0] vld  = 7'b1100011;
        logic [6:0] ex   = 7'b0000001;
        logic e;
        load(8'h0B, 4'd4, 1'b1, 1'b1);
        for (int i = 6; i >= 0; i--) begin
            q_y.push_back(ex[i]);
            step(bits[i], vld[i]);
            e = q_y.pop_front();
            n_tests++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL gap_cyc%0d: y=%b expected %b", 7 - i, y, e);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_cnt: cnt=%0d expected 1", match_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] ex = 3'b011;
        logic e;
        load(8'h03, 4'd2, 1'b1, 1'b1);
        for (int i = 2; i >= 0; i--) begin
            q_y.push_back(ex[i]);
            step(1'b1, 1'b1);
            e = q_y.pop_front();
            n_tests++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: y=%b expected %b", 3 - i, y, e);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_cnt: cnt=%0d expected 2", match_cnt);
        end
    endtask

    task automatic test_saturate;
        int c;
        load(8'h03, 4'd2, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            q_c.push_back((i - 1 > 3) ? 3 : i - 1);
            step(1'b1, 1'b1);
            c = q_c.pop_front();
            n_tests++;
            if (int'(cnt2) !== c) begin
                n_fail++;
                $display("FAIL sat_bit%0d: cnt2=%0d expected %0d", i, cnt2, c);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_wide_cnt: cnt=%0d expected 5", match_cnt);
        end
    endtask

    task automatic test_cnt_clr;
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        n_tests++;
        if (y !== 1'b1 || match_cnt !== 8'd0 || cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL clr_on_hit: y=%b cnt=%0d cnt2=%0d expected 1 0 0",
                     y, match_cnt, cnt2);
        end
        step(1'b1, 1'b1);
        n_tests++;
        if (y !== 1'b1 || match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL clr_after: y=%b cnt=%0d expected 1 1", y, match_cnt);
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] bits = 4'b1011;
        logic [4:0] post = 5'b11011;
        logic [4:0] ex   = 5'b00001;
        logic e;
        load(8'h0B, 4'd4, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) step(bits[i], 1'b1);
        n_tests++;
        if (y !== 1'b1 || match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL arst_pre: y=%b cnt=%0d expected 1 1", y, match_cnt);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (y !== 1'b0 || match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: y=%b cnt=%0d expected 0 0", y, match_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            q_y.push_back(ex[i]);
            step(post[i], 1'b1);
            e = q_y.pop_front();
            n_tests++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL arst_bit%0d: y=%b expected %b", 5 - i, y, e);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL arst_cnt: cnt=%0d expected 1", match_cnt);
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in       = 1'b0;
        cfg_load = 1'b0;
        pat_val  = '0;
        pat_len  = '0;
        overlap  = 1'b0;
        cnt_clr  = 1'b0;
        test_reset();
        test_non_overlap();
        test_len_zero();
        test_clamp();
        test_gap();
        test_back_to_back();
        test_saturate();
        test_cnt_clr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
